// File: rtl/msk_and_hpc2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : msk_and_hpc2_arbiter_if
// Description : Request, randomness, gadget and result bundle of the shared
//               masked HPC2 AND arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface msk_and_hpc2_arbiter_if #(
  parameter int D       = 2,
  parameter int N       = 4,
  parameter int HPC2RND = D * (D - 1) / 2
);
  // requester side
  logic [N-1:0]       req_valid;
  logic [N*D-1:0]     req_ina;
  logic [N*D-1:0]     req_inb;
  logic [N-1:0]       req_ready;
  // randomness source
  logic               rnd_valid;
  logic [HPC2RND-1:0] rnd_in;
  logic               rnd_ready;
  // external gadget
  logic [D-1:0]       g_ina;
  logic [D-1:0]       g_inb;
  logic [HPC2RND-1:0] g_rnd;
  logic [D-1:0]       g_out;
  // results and status
  logic [N-1:0]       res_valid;
  logic [D-1:0]       res_out;
  logic               idle;

  modport slave (
    input  req_valid, req_ina, req_inb, rnd_valid, rnd_in, g_out,
    output req_ready, rnd_ready, g_ina, g_inb, g_rnd, res_valid, res_out, idle
  );

  modport master (
    output req_valid, req_ina, req_inb, rnd_valid, rnd_in, g_out,
    input  req_ready, rnd_ready, g_ina, g_inb, g_rnd, res_valid, res_out, idle
  );
endinterface
`default_nettype wire

// File: rtl/msk_and_hpc2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : msk_and_hpc2_arbiter
// Description : Round-robin arbiter time-sharing one masked HPC2 AND gadget
//               between N requesters. inb/rnd go out at issue, ina one cycle
//               later, result returns two cycles after issue with a one-hot
//               tag. Share bits only pass through muxes and registers.
// Revision    : 1.0 - initial release
// ============================================================================
module msk_and_hpc2_arbiter #(
  parameter int D       = 2,
  parameter int N       = 4,
  parameter int HPC2RND = D * (D - 1) / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  msk_and_hpc2_arbiter_if.slave bus
);

  localparam int                 C_PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [C_PTR_W-1:0] C_LAST  = C_PTR_W'(N - 1);

  logic [C_PTR_W-1:0] r_ptr;
  logic [D-1:0]       r_ina_q;
  logic [N-1:0]       r_tag1;
  logic [N-1:0]       r_tag2;

  logic               w_found;
  logic               w_issue;
  logic [C_PTR_W-1:0] w_cand;
  logic [C_PTR_W-1:0] w_win;
  logic [C_PTR_W-1:0] w_ptr_nxt;
  logic [N-1:0]       w_grant;
  logic [D-1:0]       w_ina_sel;
  logic [D-1:0]       w_inb_sel;
  logic [HPC2RND-1:0] w_rnd;

  // Rotating-priority search: first pending requester at or after r_ptr
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = C_PTR_W'((32'(r_ptr) + 32'(k)) % N);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // An issue needs a pending request and a fresh random word; reset blocks it
  assign w_issue   = w_found & bus.rnd_valid & ~rst;
  assign w_grant   = w_issue ? (N'(1) << w_win) : '0;
  assign w_ptr_nxt = (w_win == C_LAST) ? '0 : w_win + 1'b1;
  assign w_rnd     = w_issue ? bus.rnd_in : '0;

  // Share mux driven by the one-hot grant; zero when nothing is issued
  always_comb begin
    w_ina_sel = '0;
    w_inb_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_ina_sel = bus.req_ina[i*D +: D];
        w_inb_sel = bus.req_inb[i*D +: D];
      end
    end
  end

  // Pointer, skewed ina share register and two-stage result tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_ina_q <= '0;
      r_tag1  <= '0;
      r_tag2  <= '0;
    end else begin
      if (w_issue) begin
        r_ptr <= w_ptr_nxt;
      end
      r_ina_q <= w_ina_sel;
      r_tag1  <= w_grant;
      r_tag2  <= r_tag1;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rnd_ready = w_issue;
  assign bus.g_inb     = w_inb_sel;
  assign bus.g_rnd     = w_rnd;
  assign bus.g_ina     = r_ina_q;
  assign bus.res_valid = r_tag2;
  assign bus.res_out   = bus.g_out;
  assign bus.idle      = ~|r_tag1 & ~|r_tag2;

endmodule
`default_nettype wire

// File: doc/msk_and_hpc2_arbiter.md
# msk_and_hpc2_arbiter

Round-robin arbiter and sequencer that time-shares a single external masked HPC2 AND gadget between `N` requesters. The block applies the gadget's input skew: share `inb` and the randomness at issue cycle t, share `ina` at t+1, and the output sharing is valid at t+2. It gates each issue on fresh randomness, so no random word is ever reused. Each result is returned to its originating requester with a one-hot tag. It sits between the S-box/key-schedule control units and the shared gadget instance, enabling area-reduced datapaths.

## Interface
- `d`, 2, number of shares
- `N`, 4, number of requesters (2..8)
- `hpc2rnd`, d*(d-1)/2, random bits consumed per AND
- `clk` in 1: clock, rising-edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in N: per-requester operation request
- `req_ina` in N*d: requester i's `ina` sharing in bits [i*d +: d]
- `req_inb` in N*d: requester i's `inb` sharing, same packing
- `req_ready` out N: one-hot grant, request i accepted this cycle
- `rnd_valid` in 1: fresh randomness available
- `rnd_in` in hpc2rnd: randomness word
- `rnd_ready` out 1: randomness consumed this cycle
- `g_ina` out d: gadget `ina`
- `g_inb` out d: gadget `inb`
- `g_rnd` out hpc2rnd: gadget `rnd`
- `g_out` in d: gadget output sharing
- `res_valid` out N: one-hot, result for requester i present on `res_out`
- `res_out` out d: result sharing, equal to `g_out`
- `idle` out 1: no operation in flight

## Operation
- Issue at cycle t requires `rnd_valid`=1 and at least one `req_valid`=1. Winner is the first asserted index at or after `ptr`, searching upward and wrapping modulo N.
- On issue, in the same cycle:
  - `req_ready[winner]`=1 and `rnd_ready`=1.
  - `g_inb` = winner's `inb`; `g_rnd` = `rnd_in`.
  - Winner's `ina` is registered into `ina_q`.
  - `ptr` ← (winner+1) mod N.
- Without issue: `req_ready`=0, `rnd_ready`=0, `g_inb`=0, `g_rnd`=0, and `ptr` holds.
- `g_ina` = `ina_q` on every cycle. `ina_q` is loaded with 0 on any cycle without issue, so an idle slot drives all-zero shares.
- Tag pipeline: `tag1` ← one-hot winner (or 0 on no issue); `tag2` ← `tag1`. `res_valid` = `tag2`. `res_out` = `g_out`, passed through combinationally with no recombination.
- Share domains stay separate: no logic combines different shares of one sharing. Only muxes and registers touch share bits.
- Requesters hold `req_valid` and data stable until granted. `req_valid` must not depend on `req_ready`. Results carry no backpressure, so requesters must accept on `res_valid`.
- `idle` = (`tag1`==0) && (`tag2`==0).

## Timing
- Reset values: `ptr`=0, `ina_q`=0, `tag1`=`tag2`=0. Consequently `res_valid`=0 and `idle`=1.
- `req_ready`, `rnd_ready`, `g_inb` and `g_rnd` are combinational from `req_valid`, `rnd_valid` and `ptr`.
- Latency: issue at t gives `g_ina` valid at t+1 and `res_valid` at t+2. Throughput is one AND per cycle. Back-to-back issues overlap, with `ina` of op k and `inb` of op k+1 in the same cycle.
- `rnd_valid`=0 stalls all requesters. In-flight ops still complete.
- Single requester asserting continuously is granted every cycle.
- Reset asserted in any cycle: all in-flight ops are dropped. No `res_valid` occurs in the cycles after the reset cycle, and `ptr` returns to 0. During the reset cycle itself, issue outputs are forced to 0 (`req_ready`=0, `rnd_ready`=0).
- Wrap: `ptr`=N-1 with requester N-1 granted sets `ptr` to 0.

## Test plan
- Notation: `b` is the unmasked value, the XOR of the shares of `res_out`.
- d=2, N=4, requester 2 only, ina=2'b10 (a=1), inb=2'b01 (b=1), rnd=1 at t=5:
  - `req_ready`=4'b0100 at t=5.
  - `res_valid`=4'b0100 at t=7.
  - XOR of `res_out` = 1.
  - `idle`=0 during t=6..7.
- All 4 requesters valid, `rnd_valid`=1 continuously from reset: grants 0,1,2,3,0 on consecutive cycles; `res_valid` shows the same sequence delayed by 2 cycles.
- Requester 1 valid, `rnd_valid`=0 for 3 cycles then 1: `req_ready`=0 and `rnd_ready`=0 while stalled, grant on the first cycle `rnd_valid`=1, and `g_inb`=0 during the stall.
- Requester 0 issues a=1,b=0 at t, then requester 3 issues a=1,b=1 at t+1:
  - At t+1, `g_ina`=op0's ina and `g_inb`=op1's inb.
  - Results: b=0 on `res_valid`=0001 at t+2, b=1 on `res_valid`=1000 at t+3.
- Issue at t, `rst`=1 at t+1: `res_valid`=0 at t+2 and t+3, `idle`=1 after reset, and the next grant follows `ptr`=0 priority.
- d=3, N=2, random exhaustive a/b with random sharings: every result's unmasked value = a AND b, and each `rnd_in` word is consumed exactly once.
